// File: rtl/rotary_pkg.sv
// Shared types, default parameters and the value-update arithmetic for the rotary controller.
// Pure declarations: no clocked logic, no backpressure.
package rotary_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    NOTIFY = 1'b1
  } state_t;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_ACCEL_WINDOW = 500000;
  localparam int DEF_ACCEL_STEP   = 4;

  // Adds a signed delta to an unsigned value of 'width' bits (width <= 32),
  // wrapping modulo 2^width or clamping to [0, 2^width-1].
  function automatic logic [31:0] apply_delta(input logic [31:0]        cur,
                                              input logic signed [33:0] delta,
                                              input int unsigned        width,
                                              input logic               wrap);
    logic signed [35:0] sum;
    logic signed [35:0] max_v;
    sum   = $signed({4'b0000, cur}) + $signed({{2{delta[33]}}, delta});
    max_v = (36'sd1 <<< width) - 36'sd1;
    if (wrap) begin
      return 32'(sum & max_v);
    end else if (sum < 36'sd0) begin
      return 32'd0;
    end else if (sum > max_v) begin
      return 32'(max_v);
    end else begin
      return 32'(sum);
    end
  endfunction

endpackage

// File: rtl/rotary_if.sv
// Update channel from the rotary controller to its consumer: valid/ready, one (channel, value) per beat.
// The master holds valid/ch/val stable until ready is seen high.
interface rotary_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              upd_valid;
  logic              upd_ready;
  logic [CH_W-1:0]   upd_ch;
  logic [WIDTH-1:0]  upd_val;

  modport master (
    output upd_valid,
    output upd_ch,
    output upd_val,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_ch,
    input  upd_val,
    output upd_ready
  );
endinterface

// File: rtl/rotary_accel.sv
// Step acceleration: counts cycles since the last step and reports the step magnitude for the current cycle.
// Magnitude is combinational from the registered gap; no backpressure.
module rotary_accel #(
  parameter int ACCEL_WINDOW = 500000,
  parameter int ACCEL_STEP   = 4,
  parameter int MAG_W        = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_evt,
  input  logic             ch_switch,
  output logic [MAG_W-1:0] mag
);
  localparam int            GW  = $clog2(ACCEL_WINDOW + 1);
  localparam logic [GW-1:0] WIN = GW'(ACCEL_WINDOW);

  logic [GW-1:0] gap_q, gap_d;

  // A fresh channel starts unaccelerated, so the switch outranks a same-cycle step.
  always_comb begin
    gap_d = gap_q;
    if (ch_switch) begin
      gap_d = WIN;
    end else if (step_evt) begin
      gap_d = '0;
    end else if (gap_q < WIN) begin
      gap_d = gap_q + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= WIN;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign mag = (gap_q < WIN) ? MAG_W'(ACCEL_STEP) : MAG_W'(1);

endmodule

// File: rtl/rotary_ctrl.sv
// Rotary encoder controller: accumulates accelerated steps, applies them to the selected channel, button cycles channel.
// Step-to-update latency 1 cycle from IDLE; while the consumer stalls, steps and presses keep accumulating.
module rotary_ctrl
  import rotary_pkg::*;
#(
  parameter int  NUM_CH       = DEF_NUM_CH,
  parameter int  WIDTH        = DEF_WIDTH,
  parameter int  ACCEL_WINDOW = DEF_ACCEL_WINDOW,
  parameter int  ACCEL_STEP   = DEF_ACCEL_STEP,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_cw,
  input  logic                    step_ccw,
  input  logic                    btn_press,
  input  logic                    wrap_en,
  output logic [CH_W-1:0]         ch_sel,
  output logic [NUM_CH*WIDTH-1:0] ch_val,
  rotary_if.master                upd
);
  localparam int                   PW     = WIDTH + 2;
  localparam logic signed [PW:0]   P_MAX  = (PW+1)'(2 ** WIDTH);
  localparam logic signed [PW:0]   P_MIN  = -P_MAX;
  localparam logic [CH_W-1:0]      CH_TOP = CH_W'(NUM_CH - 1);

  state_t                       state_q, state_d;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_val_q, ch_val_d;
  logic [CH_W-1:0]              ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]              upd_ch_q, upd_ch_d;
  logic [WIDTH-1:0]             upd_val_q, upd_val_d;
  logic                         upd_valid_q, upd_valid_d;
  logic signed [PW-1:0]         pending_q, pending_d;
  logic                         btn_pend_q, btn_pend_d;

  logic                         step_evt;
  logic                         ch_switch;
  logic [PW-1:0]                mag;
  logic signed [PW-1:0]         step_delta;
  logic signed [PW:0]           pend_sum;
  logic signed [PW-1:0]         pend_sat;
  logic [CH_W-1:0]              next_ch;
  logic [WIDTH-1:0]             new_val;

  // Simultaneous cw and ccw cancel out entirely, including the gap reset.
  assign step_evt = step_cw ^ step_ccw;

  rotary_accel #(
    .ACCEL_WINDOW (ACCEL_WINDOW),
    .ACCEL_STEP   (ACCEL_STEP),
    .MAG_W        (PW)
  ) u_accel (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_evt  (step_evt),
    .ch_switch (ch_switch),
    .mag       (mag)
  );

  always_comb begin
    step_delta = '0;
    if (step_evt) begin
      step_delta = step_cw ? $signed(mag) : -$signed(mag);
    end
  end

  always_comb begin
    pend_sum = $signed({pending_q[PW-1], pending_q}) + $signed({step_delta[PW-1], step_delta});
    pend_sat = PW'(pend_sum);
    if (pend_sum > P_MAX) begin
      pend_sat = PW'(P_MAX);
    end else if (pend_sum < P_MIN) begin
      pend_sat = PW'(P_MIN);
    end
  end

  assign next_ch = (ch_sel_q == CH_TOP) ? '0 : ch_sel_q + CH_W'(1);
  assign new_val = WIDTH'(apply_delta(32'(ch_val_q[ch_sel_q]), 34'(pending_q), WIDTH, wrap_en));

  always_comb begin
    state_d     = state_q;
    ch_val_d    = ch_val_q;
    ch_sel_d    = ch_sel_q;
    upd_ch_d    = upd_ch_q;
    upd_val_d   = upd_val_q;
    upd_valid_d = upd_valid_q;
    pending_d   = pend_sat;
    btn_pend_d  = btn_pend_q | btn_press;
    ch_switch   = 1'b0;
    case (state_q)
      IDLE: begin
        // Steps drain before a switch so they land on the channel they were dialled on.
        if (pending_q != '0) begin
          ch_val_d[ch_sel_q] = new_val;
          upd_ch_d           = ch_sel_q;
          upd_val_d          = new_val;
          upd_valid_d        = 1'b1;
          pending_d          = step_delta;
          state_d            = NOTIFY;
        end else if (btn_pend_q) begin
          ch_sel_d    = next_ch;
          upd_ch_d    = next_ch;
          upd_val_d   = ch_val_q[next_ch];
          upd_valid_d = 1'b1;
          btn_pend_d  = btn_press;
          ch_switch   = 1'b1;
          state_d     = NOTIFY;
        end
      end
      NOTIFY: begin
        if (upd.upd_ready) begin
          upd_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_val_q    <= '0;
      ch_sel_q    <= '0;
      upd_ch_q    <= '0;
      upd_val_q   <= '0;
      upd_valid_q <= 1'b0;
      pending_q   <= '0;
      btn_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_val_q    <= ch_val_d;
      ch_sel_q    <= ch_sel_d;
      upd_ch_q    <= upd_ch_d;
      upd_val_q   <= upd_val_d;
      upd_valid_q <= upd_valid_d;
      pending_q   <= pending_d;
      btn_pend_q  <= btn_pend_d;
    end
  end

  assign ch_sel        = ch_sel_q;
  assign ch_val        = ch_val_q;
  assign upd.upd_valid = upd_valid_q;
  assign upd.upd_ch    = upd_ch_q;
  assign upd.upd_val   = upd_val_q;

endmodule

// File: tb/tb_rotary_ctrl.sv
// Bench for rotary_ctrl with NUM_CH=4, WIDTH=8, ACCEL_WINDOW=16, ACCEL_STEP=4.
// Step table plus hand sequences for latency, consumer stall and reset during a pending update.
module tb_rotary_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_cw = 1'b0;
  logic        step_ccw = 1'b0;
  logic        btn_press = 1'b0;
  logic        wrap_en = 1'b0;
  logic [1:0]  ch_sel;
  logic [31:0] ch_val;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb_q[$];

  rotary_if #(.NUM_CH(4), .WIDTH(8)) u_if ();

  rotary_ctrl #(
    .NUM_CH       (4),
    .WIDTH        (8),
    .ACCEL_WINDOW (16),
    .ACCEL_STEP   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_cw   (step_cw),
    .step_ccw  (step_ccw),
    .btn_press (btn_press),
    .wrap_en   (wrap_en),
    .ch_sel    (ch_sel),
    .ch_val    (ch_val),
    .upd       (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cw;
    logic ccw;
    logic btn;
    logic wrap;
    int   space;
    logic exp_upd;
    int   exp_ch;
    int   exp_val;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] chv(input logic [31:0] bus, input int ch);
    return bus[ch*8 +: 8];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic cw, input logic ccw, input logic btn);
    @(posedge clk);
    #1;
    step_cw   = cw;
    step_ccw  = ccw;
    btn_press = btn;
    @(posedge clk);
    #1;
    step_cw   = 1'b0;
    step_ccw  = 1'b0;
    btn_press = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input int ch, input int val);
    sb_q.push_back({8'(ch), 8'(val)});
  endtask

  // Scoreboard: every accepted update must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && u_if.upd_valid && u_if.upd_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_update", {u_if.upd_ch, 8'(u_if.upd_val)}, 32'hffff_ffff);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        chk("upd_ch", 32'(u_if.upd_ch), 32'(e[15:8]));
        chk("upd_val", 32'(u_if.upd_val), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cw ccw btn wrap space upd ch val
    vecs[0]  = '{1, 0, 0, 0,  5, 1, 0,   1};
    vecs[1]  = '{1, 0, 0, 0, 25, 1, 0,   5};
    vecs[2]  = '{1, 0, 0, 0, 16, 1, 0,   6};
    vecs[3]  = '{1, 0, 0, 0, 17, 1, 0,  10};
    vecs[4]  = '{0, 1, 0, 0,  5, 1, 0,   9};
    vecs[5]  = '{1, 1, 0, 0, 20, 0, 0,   9};
    vecs[6]  = '{0, 1, 0, 0, 20, 1, 0,   8};
    vecs[7]  = '{0, 0, 1, 0, 20, 1, 1,   0};
    vecs[8]  = '{0, 1, 0, 0, 20, 1, 1,   0};
    vecs[9]  = '{0, 1, 0, 1, 20, 1, 1, 255};
    vecs[10] = '{1, 0, 0, 1, 20, 1, 1,   0};
    vecs[11] = '{1, 0, 0, 0,  3, 1, 1,   1};
    vecs[12] = '{0, 1, 0, 0, 20, 1, 1,   0};
    vecs[13] = '{0, 1, 0, 1,  3, 1, 1, 255};
    vecs[14] = '{1, 0, 0, 0, 20, 1, 1, 255};
    vecs[15] = '{0, 0, 1, 0,  5, 1, 2,   0};
    vecs[16] = '{0, 0, 1, 0,  5, 1, 3,   0};
    vecs[17] = '{0, 0, 1, 0,  5, 1, 0,   8};

    u_if.upd_ready = 1'b1;
    do_reset();

    chk("rst_ch_val", ch_val, 32'd0);
    chk("rst_ch_sel", 32'(ch_sel), 32'd0);
    chk("rst_upd_valid", 32'(u_if.upd_valid), 32'd0);
    chk("rst_upd_ch", 32'(u_if.upd_ch), 32'd0);
    chk("rst_upd_val", 32'(u_if.upd_val), 32'd0);

    // First step: value and update appear exactly one edge after the sampling edge.
    push_exp(0, 1);
    @(posedge clk);
    #1;
    step_cw = 1'b1;
    @(posedge clk);
    #1;
    step_cw = 1'b0;
    chk("lat_k_valid", 32'(u_if.upd_valid), 32'd0);
    chk("lat_k_val", 32'(chv(ch_val, 0)), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_k1_valid", 32'(u_if.upd_valid), 32'd1);
    chk("lat_k1_val", 32'(chv(ch_val, 0)), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_k2_valid", 32'(u_if.upd_valid), 32'd0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      wrap_en = vecs[i].wrap;
      if (vecs[i].exp_upd) push_exp(vecs[i].exp_ch, vecs[i].exp_val);
      pulse(vecs[i].cw, vecs[i].ccw, vecs[i].btn);
      idle(vecs[i].space - 2);
      chk($sformatf("vec%0d_ch_sel", i), 32'(ch_sel), 32'(vecs[i].exp_ch));
      chk($sformatf("vec%0d_ch_val", i), 32'(chv(ch_val, vecs[i].exp_ch)), 32'(vecs[i].exp_val));
    end

    // Consumer stall: held update, further steps and a press queue up behind it.
    wrap_en = 1'b0;
    do_reset();
    u_if.upd_ready = 1'b0;
    push_exp(0, 1);
    pulse(1'b1, 1'b0, 1'b0);
    idle(3);
    chk("busy_valid", 32'(u_if.upd_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(18);
      pulse(1'b1, 1'b0, 1'b0);
      idle(2);
      chk($sformatf("busy_hold_val%0d", i), 32'(u_if.upd_val), 32'd1);
      chk($sformatf("busy_hold_vld%0d", i), 32'(u_if.upd_valid), 32'd1);
    end
    chk("busy_ch_val", 32'(chv(ch_val, 0)), 32'd1);
    push_exp(0, 4);
    push_exp(1, 0);
    pulse(1'b0, 1'b0, 1'b1);
    idle(2);
    u_if.upd_ready = 1'b1;
    idle(10);
    chk("busy_ch_sel", 32'(ch_sel), 32'd1);
    chk("busy_ch0", 32'(chv(ch_val, 0)), 32'd4);

    // Reset while an update is waiting for the consumer.
    u_if.upd_ready = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !u_if.upd_valid; i++) idle(1);
    chk("rstmid_wait_valid", 32'(u_if.upd_valid), 32'd1);
    chk("rstmid_pre_ch1", 32'(chv(ch_val, 1)), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(u_if.upd_valid), 32'd0);
    chk("rstmid_ch_sel", 32'(ch_sel), 32'd0);
    chk("rstmid_ch_val", ch_val, 32'd0);
    chk("rstmid_upd_val", 32'(u_if.upd_val), 32'd0);
    idle(2);
    rst_n = 1'b1;
    u_if.upd_ready = 1'b1;
    idle(5);
    chk("rstmid_post_valid", 32'(u_if.upd_valid), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
